// File: rtl/tablero_pkg.sv
// ---------------------------------------------------------------------------
// tablero_pkg
// Shared definitions for the dashboard turn-signal path. The lever front end
// and the LED sequencer both import this so the turn codes agree at both ends.
//   TURN_*        : 2-bit turn codes carried on turn[1:0]
//   turn_state_e  : lever FSM state encoding
//   turn_code()   : state -> turn code mapping
// ---------------------------------------------------------------------------
package tablero_pkg;

    localparam logic [1:0] TURN_OFF   = 2'b00;
    localparam logic [1:0] TURN_LEFT  = 2'b01;
    localparam logic [1:0] TURN_RIGHT = 2'b10;

    typedef enum logic [1:0] {
        ST_OFF       = 2'b00,
        ST_LEFT      = 2'b01,
        ST_RIGHT     = 2'b10,
        ST_CANCELLED = 2'b11
    } turn_state_e;

    // CANCELLED shows as off so the sequencer needs no knowledge of it.
    function automatic logic [1:0] turn_code(input turn_state_e st);
        logic [1:0] code;
        case (st)
            ST_LEFT:  code = TURN_LEFT;
            ST_RIGHT: code = TURN_RIGHT;
            default:  code = TURN_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lever_debounce.sv
// ---------------------------------------------------------------------------
// lever_debounce
// Two-flop synchronizer followed by a debounce counter for one raw contact.
// A changed level must be seen for DEBOUNCE_CYCLES consecutive clocks before
// it is accepted; any return to the stable level restarts the count.
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   din  : raw, asynchronous contact input
//   dout : debounced level, synchronous to clk
// ---------------------------------------------------------------------------
module lever_debounce
    import tablero_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            // Accepting the new level also leaves the counter at zero, so it
            // never reaches a value it could wrap from.
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/turn_lever_ctrl.sv
// ---------------------------------------------------------------------------
// turn_lever_ctrl
// Front end for the turn-signal sequencer: debounces the lever contacts and
// hazard button, runs the turn FSM and the hazard toggle latch.
//   clk         : system clock
//   rst         : asynchronous reset, active-high
//   lever_left  : raw lever-left contact (async)
//   lever_right : raw lever-right contact (async)
//   hazard_btn  : raw hazard push-button (async)
//   turn[1:0]   : registered turn code (00 off, 01 left, 10 right)
//   hazard      : registered hazard latch
// Build option: define AUTO_CANCEL_EN to cancel a turn indication after
// CANCEL_CYCLES clocks; without it the turn code follows the lever.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_OFF       | lever neutral (or contact fault), turn = 00
// ST_LEFT      | lever held left, turn = 01
// ST_RIGHT     | lever held right, turn = 10
// ST_CANCELLED | auto-cancel fired, turn = 00 until lever goes neutral
//              | or swaps direction (AUTO_CANCEL_EN only)
// ---------------------------------------------------------------------------
module turn_lever_ctrl
    import tablero_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CANCEL_CYCLES   = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lever_left,
    input  logic       lever_right,
    input  logic       hazard_btn,
    output logic [1:0] turn,
    output logic       hazard
);

    if (DEBOUNCE_CYCLES < 2 || CANCEL_CYCLES < 2) begin : g_bad_params
        $error("turn_lever_ctrl: DEBOUNCE_CYCLES and CANCEL_CYCLES must be >= 2");
    end

    logic left_db, right_db, hz_db;

    lever_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk (clk), .rst (rst), .din (lever_left),  .dout (left_db)
    );
    lever_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk (clk), .rst (rst), .din (lever_right), .dout (right_db)
    );
    lever_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hazard (
        .clk (clk), .rst (rst), .din (hazard_btn),  .dout (hz_db)
    );

    turn_state_e state_q, state_d;
    turn_state_e lever_tgt;
    logic [1:0]  turn_q, turn_d;
    logic        hazard_q, hazard_d;
    logic        hz_prev_q, hz_prev_d;

`ifdef AUTO_CANCEL_EN
    localparam int            TW       = $clog2(CANCEL_CYCLES);
    localparam logic [TW-1:0] TMR_LOAD = TW'(CANCEL_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    turn_state_e   cdir_q, cdir_d;
`endif

    // Both contacts closed is a fault and reads as neutral.
    always_comb begin
        lever_tgt = ST_OFF;
        if (left_db && !right_db) begin
            lever_tgt = ST_LEFT;
        end else if (right_db && !left_db) begin
            lever_tgt = ST_RIGHT;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef AUTO_CANCEL_EN
        timer_d = timer_q;
        cdir_d  = cdir_q;
`endif
        case (state_q)
            ST_OFF: begin
                state_d = lever_tgt;
            end
            ST_LEFT, ST_RIGHT: begin
                state_d = lever_tgt;
`ifdef AUTO_CANCEL_EN
                if (lever_tgt == state_q && timer_q == '0) begin
                    state_d = ST_CANCELLED;
                end
`endif
            end
`ifdef AUTO_CANCEL_EN
            ST_CANCELLED: begin
                // Holding the cancelled direction keeps us parked here.
                if (lever_tgt == ST_OFF) begin
                    state_d = ST_OFF;
                end else if (lever_tgt != cdir_q) begin
                    state_d = lever_tgt;
                end
            end
`endif
            default: begin
                state_d = ST_OFF;
            end
        endcase

`ifdef AUTO_CANCEL_EN
        // Down-counter: loaded on any entry to LEFT/RIGHT (including a direct
        // swap), terminal count at zero.
        if ((state_d == ST_LEFT || state_d == ST_RIGHT) && state_d != state_q) begin
            timer_d = TMR_LOAD;
        end else if ((state_q == ST_LEFT || state_q == ST_RIGHT) && timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end
        if (state_d == ST_CANCELLED && state_q != ST_CANCELLED) begin
            cdir_d = state_q;
        end
`endif
    end

    // turn is registered from the next state so it lands on the same edge
    // as the state register rather than one clock later.
    always_comb begin
        turn_d    = turn_code(state_d);
        hz_prev_d = hz_db;
        hazard_d  = hazard_q ^ (hz_db & ~hz_prev_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_OFF;
            turn_q    <= TURN_OFF;
            hazard_q  <= 1'b0;
            hz_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            hazard_q  <= hazard_d;
            hz_prev_q <= hz_prev_d;
        end
    end

`ifdef AUTO_CANCEL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            cdir_q  <= ST_OFF;
        end else begin
            timer_q <= timer_d;
            cdir_q  <= cdir_d;
        end
    end
`endif

    assign turn   = turn_q;
    assign hazard = hazard_q;

endmodule

// File: tb/tb_turn_lever_ctrl.sv
// ---------------------------------------------------------------------------
// tb_turn_lever_ctrl
// Scoreboard bench for turn_lever_ctrl with DEBOUNCE_CYCLES=4,
// CANCEL_CYCLES=20. Stimulus is applied on the falling edge; each stimulus
// step schedules the expected {turn,hazard} value for specific future cycles,
// and the monitor compares them 1 time unit after each rising edge.
// With DEBOUNCE_CYCLES=4 a raw edge applied at cycle n shows at the outputs
// after rising edge n+7 and not before.
// ---------------------------------------------------------------------------
module tb_turn_lever_ctrl;

    logic       clk;
    logic       rst;
    logic       lever_left;
    logic       lever_right;
    logic       hazard_btn;
    logic [1:0] turn;
    logic       hazard;

    turn_lever_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CANCEL_CYCLES   (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lever_left  (lever_left),
        .lever_right (lever_right),
        .hazard_btn  (hazard_btn),
        .turn        (turn),
        .hazard      (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      tag;
        logic [2:0] val;   // {turn, hazard}
    } sb_item_t;

    sb_item_t sb[$];
    int       cyc = 0;
    int       n_checks = 0;
    int       n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s: got %0b want %0b (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    task automatic expect_at(input int c, input string tag, input logic [2:0] v);
        sb_item_t it;
        int       pos;
        it.cyc = c;
        it.tag = tag;
        it.val = v;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, it);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    sb_item_t mon_it;
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_it = sb.pop_front();
            chk_eq(mon_it.tag, 32'({turn, hazard}), 32'(mon_it.val));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int t;
        int len;

        rst         = 1'b1;
        lever_left  = 1'b0;
        lever_right = 1'b0;
        hazard_btn  = 1'b0;
        step(1);
        chk_eq("reset_state", 32'({turn, hazard}), 32'b000);
        step(2);
        rst = 1'b0;
        step(5);

        // left press and release
        n = cyc; lever_left = 1'b1;
        expect_at(n + 6, "left_pre", 3'b000);
        expect_at(n + 7, "left_on",  3'b010);
        step(15);
        n = cyc; lever_left = 1'b0;
        expect_at(n + 6, "left_hold", 3'b010);
        expect_at(n + 7, "left_off",  3'b000);
        step(10);

        // right contact bounce, then a clean hold
        t = 0;
        while (t < 30) begin
            len = $urandom_range(1, 3);
            lever_right = ~lever_right;
            for (int k = 0; k < len; k++) begin
                expect_at(cyc + 6, "bounce_quiet", 3'b000);
                step(1);
            end
            t += len;
        end
        lever_right = 1'b0;
        expect_at(cyc + 6, "bounce_quiet", 3'b000);
        step(1);
        n = cyc; lever_right = 1'b1;
        expect_at(n + 6, "bounce_pre", 3'b000);
        expect_at(n + 7, "bounce_on",  3'b100);
        step(10);

        // direct swaps and contact fault
        n = cyc; lever_right = 1'b0; lever_left = 1'b1;
        expect_at(n + 6, "swap_rl_pre", 3'b100);
        expect_at(n + 7, "swap_rl",     3'b010);
        step(12);
        n = cyc; lever_left = 1'b0; lever_right = 1'b1;
        expect_at(n + 6, "swap_lr_pre", 3'b010);
        expect_at(n + 7, "swap_lr",     3'b100);
        step(12);
        n = cyc; lever_left = 1'b1;
        expect_at(n + 6, "fault_pre", 3'b100);
        expect_at(n + 7, "fault_off", 3'b000);
        step(10);
        n = cyc; lever_left = 1'b0; lever_right = 1'b0;
        expect_at(n + 7, "both_rel", 3'b000);
        step(10);

        // hazard toggle
        n = cyc; hazard_btn = 1'b1;
        expect_at(n + 6, "hz_pre", 3'b000);
        expect_at(n + 7, "hz_on",  3'b001);
        step(10);
        n = cyc; hazard_btn = 1'b0;
        expect_at(n + 7,  "hz_release", 3'b001);
        expect_at(n + 10, "hz_release", 3'b001);
        step(8);
        n = cyc; hazard_btn = 1'b1;
        expect_at(n + 6, "hz_pre2", 3'b001);
        expect_at(n + 7, "hz_off",  3'b000);
        step(10);
        n = cyc; hazard_btn = 1'b0;
        expect_at(n + 7, "hz_release2", 3'b000);
        step(8);

        // lever and hazard events in the same cycle
        n = cyc; lever_left = 1'b1; hazard_btn = 1'b1;
        expect_at(n + 6, "simul_pre", 3'b000);
        expect_at(n + 7, "simul_on",  3'b011);
        step(10);
        n = cyc; lever_left = 1'b0; hazard_btn = 1'b0;
        expect_at(n + 6, "simul_hold", 3'b011);
        expect_at(n + 7, "simul_rel",  3'b001);
        step(10);

        // asynchronous reset mid-operation
        n = cyc; lever_right = 1'b1;
        expect_at(n + 6, "prerst_pre", 3'b001);
        expect_at(n + 7, "prerst_on",  3'b101);
        step(10);
        #2 rst = 1'b1;
        #1 chk_eq("rst_async", 32'({turn, hazard}), 32'b000);
        hazard_btn = 1'b1;
        step(3);
        chk_eq("rst_held", 32'({turn, hazard}), 32'b000);
        n = cyc; rst = 1'b0;
        expect_at(n + 6, "postrst_pre", 3'b000);
        expect_at(n + 7, "postrst_on",  3'b101);
        step(10);
        n = cyc; lever_right = 1'b0; hazard_btn = 1'b0;
        expect_at(n + 6, "postrst_hold", 3'b101);
        expect_at(n + 7, "postrst_off",  3'b001);
        step(10);

        // long hold: auto-cancel or indefinite
        n = cyc; lever_left = 1'b1;
        expect_at(n + 6, "long_pre", 3'b001);
        expect_at(n + 7, "long_on",  3'b011);
`ifdef AUTO_CANCEL_EN
        expect_at(n + 26, "cancel_last", 3'b011);
        expect_at(n + 27, "cancel_off",  3'b001);
        expect_at(n + 40, "cancel_held", 3'b001);
        step(45);
        n = cyc; lever_left = 1'b0;
        expect_at(n + 7, "cancel_rel", 3'b001);
        step(10);
        n = cyc; lever_left = 1'b1;
        expect_at(n + 6, "rearm_pre", 3'b001);
        expect_at(n + 7, "rearm_on",  3'b011);
        step(10);
`else
        expect_at(n + 27,  "nocancel_20",  3'b011);
        expect_at(n + 57,  "nocancel_50",  3'b011);
        expect_at(n + 117, "nocancel_110", 3'b011);
        step(120);
`endif

        for (int i = 0; i < 200 && sb.size() > 0; i++) step(1);
        chk_eq("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
